fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch and sequencing for a single-issue processor.
// Owns the PC, stalls on user input (IN opcode), and handles halt/resume.
module fetch_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] imem_data,
    input  logic        pc_selector,
    input  logic [9:0]  jump_target,
    input  logic        halt,
    input  logic        input_valid,
    input  logic        resume,
    output logic [9:0]  imem_addr,
    output logic [9:0]  pc,
    output logic [31:0] instruction,
    output logic        commit,
    output logic        input_ack,
    output logic        halted,
    output logic [15:0] retired_count
);
    localparam logic [31:0] NOP_WORD = 32'h2000_0000;
    localparam logic [4:0]  OP_IN    = 5'b01100;

    typedef enum logic [1:0] {RUN, WAIT_IN, HALTED} state_t;

    state_t     state, state_next;
    logic [9:0] pc_next;
    logic [9:0] pc_step;
    logic       armed;
    logic       consume;
    logic       is_in;
    logic       input_ready;

    assign imem_addr   = pc;
    assign halted      = (state == HALTED);
    assign instruction = halted ? NOP_WORD : imem_data;
    assign is_in       = (instruction[31:27] == OP_IN);
    assign pc_step     = pc + 10'd1;
    // A level-held input word may only be taken once; armed re-enables after it drops.
    assign input_ready = input_valid && armed;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_next = state;
        pc_next    = pc;
        commit     = 1'b0;
        consume    = 1'b0;
        case (state)
            RUN: begin
                if (halt) begin
                    state_next = HALTED;
                    commit     = 1'b1;
                end else if (is_in && !input_ready) begin
                    state_next = WAIT_IN;
                end else begin
                    commit  = 1'b1;
                    consume = is_in;
                    pc_next = pc_selector ? jump_target : pc_step;
                end
            end
            // Return to RUN with pc held; the IN itself completes on the next RUN cycle.
            WAIT_IN: begin
                if (input_ready) state_next = RUN;
            end
            HALTED: begin
                if (resume) begin
                    state_next = RUN;
                    pc_next    = pc_step;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= RUN;
            pc            <= 10'd0;
            armed         <= 1'b1;
            input_ack     <= 1'b0;
            retired_count <= 16'd0;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            input_ack     <= consume;
            retired_count <= retired_count + {15'd0, commit};
            if (!input_valid)
                armed <= 1'b1;
            else if (consume)
                armed <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle scoreboard of pc, address,
// instruction, commit, input_ack and halted against hand-derived scenarios.
module tb_fetch_unit;
    localparam logic [31:0] NOP_WORD = 32'h2000_0000;
    localparam logic [31:0] ADD_WORD = 32'h0800_0001;
    localparam logic [31:0] IN_WORD  = 32'h6000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_data;
    logic        pc_selector = 1'b0;
    logic [9:0]  jump_target = 10'd0;
    logic        halt = 1'b0;
    logic        input_valid = 1'b0;
    logic        resume = 1'b0;
    logic [9:0]  imem_addr;
    logic [9:0]  pc;
    logic [31:0] instruction;
    logic        commit;
    logic        input_ack;
    logic        halted;
    logic [15:0] retired_count;

    logic [31:0] imem [1024];
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [9:0]  pc;
        logic [9:0]  addr;
        logic [31:0] instr;
        logic        commit;
        logic        ack;
        logic        halted;
    } obs_t;

    typedef struct {
        logic       h, s;
        logic [9:0] t;
        logic       v, r;
        logic [9:0] pc;
        logic       commit, ack, halted;
    } step_t;

    obs_t exp_q[$];

    fetch_unit dut (
        .clock(clock), .reset(reset), .imem_data(imem_data),
        .pc_selector(pc_selector), .jump_target(jump_target), .halt(halt),
        .input_valid(input_valid), .resume(resume), .imem_addr(imem_addr),
        .pc(pc), .instruction(instruction), .commit(commit),
        .input_ack(input_ack), .halted(halted), .retired_count(retired_count)
    );

    assign imem_data = imem[imem_addr];
    always #5 clock = ~clock;

    function automatic step_t st(input logic h, input logic s, input logic [9:0] t,
                                 input logic v, input logic r, input logic [9:0] epc,
                                 input logic ec, input logic ea, input logic eh);
        step_t x;
        x.h = h; x.s = s; x.t = t; x.v = v; x.r = r;
        x.pc = epc; x.commit = ec; x.ack = ea; x.halted = eh;
        return x;
    endfunction

    function automatic obs_t expect_of(input step_t x);
        obs_t o;
        o.pc = x.pc; o.addr = x.pc;
        o.instr = x.halted ? NOP_WORD : imem[x.pc];
        o.commit = x.commit; o.ack = x.ack; o.halted = x.halted;
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.pc = pc; o.addr = imem_addr; o.instr = instruction;
        o.commit = commit; o.ack = input_ack; o.halted = halted;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("pc=%h addr=%h instr=%h commit=%b ack=%b halted=%b",
                         o.pc, o.addr, o.instr, o.commit, o.ack, o.halted);
    endfunction

    // Apply one cycle of stimulus after the falling edge and let outputs settle.
    task automatic drive(input step_t x);
        @(negedge clock);
        halt = x.h; pc_selector = x.s; jump_target = x.t;
        input_valid = x.v; resume = x.r;
        #1;
    endtask

    task automatic test_reset();
        obs_t got, want;
        #1 reset = 1'b1;
        #1;
        exp_q.push_back(expect_of(st(0, 0, 0, 0, 0, 10'h000, 1, 0, 0)));
        got = observe();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_state: got %s want %s", fmt(got), fmt(want));
        end
        checks++;
        if (retired_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_retired: got %0d want 0", retired_count);
        end
        @(posedge clock);
        #2 reset = 1'b0;
    endtask

    task automatic test_sequential();
        obs_t got, want;
        step_t tbl[$];
        for (int i = 0; i < 4; i++) tbl.push_back(st(0, 0, 0, 0, 0, 10'(i), 1, 0, 0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            exp_q.push_back(expect_of(tbl[i]));
            got = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL sequential[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end
        end
        @(posedge clock);
        #1;
        checks++;
        if (retired_count !== 16'd4 || pc !== 10'd4) begin
            errors++;
            $display("FAIL sequential_retired: got count=%0d pc=%h want count=4 pc=004", retired_count, pc);
        end
    endtask

    task automatic test_jump_wrap();
        obs_t got, want;
        step_t tbl[$];
        tbl.push_back(st(0, 1, 10'h3FF, 0, 0, 10'h004, 1, 0, 0));
        tbl.push_back(st(0, 0, 10'h000, 0, 0, 10'h3FF, 1, 0, 0));
        tbl.push_back(st(0, 1, 10'h005, 0, 0, 10'h000, 1, 0, 0));
        tbl.push_back(st(0, 1, 10'h120, 0, 0, 10'h005, 1, 0, 0));
        tbl.push_back(st(0, 0, 10'h000, 0, 0, 10'h120, 1, 0, 0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            exp_q.push_back(expect_of(tbl[i]));
            got = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL jump_wrap[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    // IN at 7 and 8 with valid held high across both; 9 is an IN left pending.
    task automatic test_in_handshake();
        obs_t got, want;
        step_t tbl[$];
        tbl.push_back(st(0, 1, 10'h007, 0, 0, 10'h121, 1, 0, 0));
        tbl.push_back(st(0, 0, 10'h000, 0, 0, 10'h007, 0, 0, 0));
        tbl.push_back(st(0, 1, 10'h3FF, 0, 0, 10'h007, 0, 0, 0));
        tbl.push_back(st(1, 1, 10'h3FF, 0, 0, 10'h007, 0, 0, 0));
        tbl.push_back(st(0, 0, 10'h000, 1, 0, 10'h007, 0, 0, 0));
        tbl.push_back(st(0, 0, 10'h000, 1, 0, 10'h007, 1, 0, 0));
        tbl.push_back(st(0, 0, 10'h000, 1, 0, 10'h008, 0, 1, 0));
        tbl.push_back(st(1, 1, 10'h3FF, 1, 0, 10'h008, 0, 0, 0));
        tbl.push_back(st(0, 0, 10'h000, 0, 0, 10'h008, 0, 0, 0));
        tbl.push_back(st(0, 0, 10'h000, 1, 0, 10'h008, 0, 0, 0));
        tbl.push_back(st(0, 0, 10'h000, 1, 0, 10'h008, 1, 0, 0));
        tbl.push_back(st(0, 0, 10'h000, 1, 0, 10'h009, 0, 1, 0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            exp_q.push_back(expect_of(tbl[i]));
            got = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL in_handshake[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t got, want;
        step_t first;
        drive(st(0, 0, 10'h000, 0, 0, 10'h009, 0, 0, 0));
        @(posedge clock);
        #1;
        checks++;
        if (retired_count !== 16'd12 || pc !== 10'h009 || commit !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_wait: got count=%0d pc=%h commit=%b want count=12 pc=009 commit=0",
                     retired_count, pc, commit);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (pc !== 10'h000 || halted !== 1'b0 || retired_count !== 16'd0 || input_ack !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got pc=%h halted=%b count=%0d ack=%b want pc=000 halted=0 count=0 ack=0",
                     pc, halted, retired_count, input_ack);
        end
        @(posedge clock);
        #2 reset = 1'b0;
        first = st(0, 0, 10'h000, 0, 0, 10'h000, 1, 0, 0);
        drive(first);
        exp_q.push_back(expect_of(first));
        got = observe();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL post_reset_fetch: got %s want %s", fmt(got), fmt(want));
        end
    endtask

    // halt/pc_selector are toggled while HALTED and must be ignored; also resume at 3FF wraps.
    task automatic test_halt_resume();
        obs_t got, want;
        step_t tbl[$];
        tbl.push_back(st(0, 1, 10'd20, 0, 0, 10'h001, 1, 0, 0));
        tbl.push_back(st(1, 0, 10'h000, 0, 0, 10'd20, 1, 0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(st(1, 1, 10'h3FF, 0, 0, 10'd20, 0, 0, 1));
        tbl.push_back(st(0, 0, 10'h000, 0, 1, 10'd20, 0, 0, 1));
        tbl.push_back(st(0, 1, 10'h3FF, 0, 0, 10'd21, 1, 0, 0));
        tbl.push_back(st(1, 0, 10'h000, 0, 0, 10'h3FF, 1, 0, 0));
        tbl.push_back(st(0, 0, 10'h000, 0, 1, 10'h3FF, 0, 0, 1));
        tbl.push_back(st(0, 0, 10'h000, 0, 0, 10'h000, 1, 0, 0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            exp_q.push_back(expect_of(tbl[i]));
            got = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL halt_resume[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    // Halt wins over a ready IN at 30; armed stays set so the IN at 31 completes at once.
    task automatic test_halt_with_in();
        obs_t got, want;
        step_t tbl[$];
        tbl.push_back(st(0, 1, 10'd30, 0, 0, 10'h001, 1, 0, 0));
        tbl.push_back(st(1, 0, 10'h000, 1, 0, 10'd30, 1, 0, 0));
        tbl.push_back(st(0, 0, 10'h000, 1, 1, 10'd30, 0, 0, 1));
        tbl.push_back(st(0, 0, 10'h000, 1, 0, 10'd31, 1, 0, 0));
        tbl.push_back(st(0, 0, 10'h000, 0, 0, 10'd32, 1, 1, 0));
        tbl.push_back(st(0, 0, 10'h000, 0, 0, 10'd33, 1, 0, 0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            exp_q.push_back(expect_of(tbl[i]));
            got = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL halt_with_in[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = ADD_WORD;
        imem[7]  = IN_WORD;
        imem[8]  = IN_WORD;
        imem[9]  = IN_WORD;
        imem[30] = IN_WORD;
        imem[31] = IN_WORD;
        test_reset();
        test_sequential();
        test_jump_wrap();
        test_in_handshake();
        test_async_reset();
        test_halt_resume();
        test_halt_with_in();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
